// File: rtl/hc595_pkg.sv
// Shared frame geometry and bit-to-field mapping for the 74HC595 seven-segment link.
// Used by both the transmitter and the hc595_rx receiver.
package hc595_pkg;

  localparam int HC595_FRAME_BITS = 14;
  localparam int HC595_SEL_W      = 6;
  localparam int HC595_SEG_W      = 8;
  localparam int HC595_CNT_SAT    = 15;
  localparam int HC595_CNT_W      = $clog2(HC595_CNT_SAT + 1);

  // sel[0] goes out first, so after a full frame it sits at the far end of the chain
  localparam int HC595_SEL0_POS   = HC595_FRAME_BITS - 1;
  localparam int HC595_SEG_LSB    = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFTING,
    RX_OVERRUN
  } hc595_rx_state_t;

  function automatic logic [HC595_SEL_W-1:0] hc595_sel_of(input logic [HC595_FRAME_BITS-1:0] frame);
    logic [HC595_SEL_W-1:0] sel_v;
    sel_v = '0;
    for (int i = 0; i < HC595_SEL_W; i++) begin
      sel_v[i] = frame[HC595_SEL0_POS - i];
    end
    return sel_v;
  endfunction

  function automatic logic [HC595_SEG_W-1:0] hc595_seg_of(input logic [HC595_FRAME_BITS-1:0] frame);
    return frame[HC595_SEG_LSB +: HC595_SEG_W];
  endfunction

endpackage

// File: rtl/hc595_rx_if.sv
// Serial 595 link lines plus the decoded frame outputs of the receiver.
interface hc595_rx_if;
  import hc595_pkg::*;

  logic                   ds;
  logic                   shcp;
  logic                   stcp;
  logic [HC595_SEL_W-1:0] sel;
  logic [HC595_SEG_W-1:0] seg;
  logic                   frame_vld;
  logic                   frame_err;

  modport master (
    output ds, shcp, stcp,
    input  sel, seg, frame_vld, frame_err
  );

  modport slave (
    input  ds, shcp, stcp,
    output sel, seg, frame_vld, frame_err
  );

endinterface

// File: rtl/hc595_rx_in.sv
// Per-line input stage: optional 2-flop synchronizer (HC595_RX_SYNC_EN), sample
// register and rising-edge detect.
module hc595_rx_in (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic stage_in;

`ifdef HC595_RX_SYNC_EN
  logic meta_p0;
  logic meta_p1;

  // synchronizer stages
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_p0 <= 1'b0;
      meta_p1 <= 1'b0;
    end else begin
      meta_p0 <= din;
      meta_p1 <= meta_p0;
    end
  end

  assign stage_in = meta_p1;
`else
  assign stage_in = din;
`endif

  logic smp_p0;
  logic smp_p1;

  // sample register and previous sample for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp_p0 <= 1'b0;
      smp_p1 <= 1'b0;
    end else begin
      smp_p0 <= stage_in;
      smp_p1 <= smp_p0;
    end
  end

  assign lvl  = smp_p0;
  assign rise = smp_p0 & ~smp_p1;

endmodule

// File: rtl/hc595_rx.sv
// 74HC595 link receiver: rebuilds the 14-bit frame from ds/shcp/stcp and presents
// decoded sel/seg with frame_vld/frame_err pulses. Option: HC595_RX_SYNC_EN.
module hc595_rx
  import hc595_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  hc595_rx_if.slave  link
);

  logic ds_lvl;
  logic ds_rise_unused;
  logic shcp_lvl_unused;
  logic shcp_rise;
  logic stcp_lvl_unused;
  logic stcp_rise;

  hc595_rx_in u_in_ds (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (link.ds),
    .lvl       (ds_lvl),
    .rise      (ds_rise_unused)
  );

  hc595_rx_in u_in_shcp (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (link.shcp),
    .lvl       (shcp_lvl_unused),
    .rise      (shcp_rise)
  );

  hc595_rx_in u_in_stcp (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (link.stcp),
    .lvl       (stcp_lvl_unused),
    .rise      (stcp_rise)
  );

  localparam logic [HC595_CNT_W-1:0] CNT_FULL = HC595_CNT_W'(HC595_FRAME_BITS);

  logic [HC595_FRAME_BITS-1:0] sr;
  logic [HC595_CNT_W-1:0]      bit_cnt;
  hc595_rx_state_t             state;

  // frame assembly, strobe decode and output latch
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr             <= '0;
      bit_cnt        <= '0;
      state          <= RX_IDLE;
      link.sel       <= '0;
      link.seg       <= '0;
      link.frame_vld <= 1'b0;
      link.frame_err <= 1'b0;
    end else begin
      link.frame_vld <= 1'b0;
      link.frame_err <= 1'b0;

      if (shcp_rise) begin
        sr <= {sr[HC595_FRAME_BITS-2:0], ds_lvl};
      end

      if (stcp_rise) begin
        // latch decisions use the pre-shift frame and pre-increment count
        if (bit_cnt == CNT_FULL) begin
          link.sel       <= hc595_sel_of(sr);
          link.seg       <= hc595_seg_of(sr);
          link.frame_vld <= 1'b1;
        end else if (bit_cnt != '0) begin
          link.frame_err <= 1'b1;
        end
        bit_cnt <= shcp_rise ? HC595_CNT_W'(1) : '0;
        state   <= shcp_rise ? RX_SHIFTING : RX_IDLE;
      end else if (shcp_rise) begin
        case (state)
          RX_IDLE: begin
            bit_cnt <= HC595_CNT_W'(1);
            state   <= RX_SHIFTING;
          end
          RX_SHIFTING: begin
            bit_cnt <= bit_cnt + HC595_CNT_W'(1);
            if (bit_cnt == CNT_FULL) begin
              state <= RX_OVERRUN;
            end
          end
          RX_OVERRUN: begin
            bit_cnt <= HC595_CNT_W'(HC595_CNT_SAT);
          end
          default: begin
            bit_cnt <= '0;
            state   <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule
